sram_burst: RTL and testbench
=============================

# sram_burst

Parametrised single-port synchronous SRAM with per-byte write strobes, registered read data with a valid flag, and multi-beat incrementing read bursts. An optional post-reset clear sequencer zeroes the whole array before the first access. It replaces fixed-size, combinational-read memories wherever a core or DMA engine needs sized, pipelined, burst-capable local storage.

## Interface

- DATA_WIDTH, 32: word width in bits; must be a multiple of 8. NUM_BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 10: word address width; DEPTH = 2^ADDR_WIDTH.
- BURST_WIDTH, 3: width of burst_len; a burst has at most 2^BURST_WIDTH beats.
- CLEAR_ON_RESET, 1: 1 runs the clear sequence after reset; 0 goes straight to IDLE.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_  in  1  reset; one clock, asynchronous assert, active-low.
- cs_  in  1  chip select, active-low; a request is accepted at an edge where cs_=0 and busy=0.
- rw_  in  1  1 = read, 0 = write.
- addr  in  ADDR_WIDTH  word address (start address for bursts).
- idata  in  DATA_WIDTH  write data.
- be  in  NUM_BYTES  byte write enables, active-high; be[i] covers idata[8i+7:8i].
- burst_len  in  BURST_WIDTH  read beats minus one; ignored for writes.
- odata  out  DATA_WIDTH  registered read data; 0 whenever ovalid=0.
- ovalid  out  1  odata carries a read beat this cycle.
- busy  out  1  requests are not accepted; cs_ is ignored while high.

## Operation

- States: CLEAR, IDLE, BURST.
- Reset (rst_=0): state = CLEAR if CLEAR_ON_RESET else IDLE; clear counter = 0; burst counters = 0; odata=0, ovalid=0, busy=CLEAR_ON_RESET. Array contents are not reset, except through CLEAR.
- CLEAR: writes 0 to word clear_cnt each cycle, from 0 to DEPTH-1, taking DEPTH cycles. After the write of DEPTH-1, the state goes to IDLE and busy falls.
- IDLE, write accepted: for each i with be[i]=1, mem[addr] byte i <= idata byte i. Other bytes are unchanged. be=0 is a legal no-op. The state stays IDLE and there is no ovalid.
- IDLE, read accepted: beat 0 reads mem[addr] into odata and sets ovalid=1. If burst_len=0, the state stays IDLE. Otherwise the block latches next address = addr+1 and remaining = burst_len, then moves to BURST.
- BURST: each cycle it reads the next address into odata with ovalid=1, increments the address modulo DEPTH (DEPTH-1 wraps to 0) and decrements remaining. When the beat with remaining=1 is issued, the state returns to IDLE.
- cs_, rw_, addr, idata, be and burst_len are ignored in CLEAR and BURST. Requests during busy are dropped, not queued. The requester must sample busy.
- busy = (state != IDLE).

## Timing

- Accepted read at edge E0: beat k is valid on odata/ovalid in the cycle after edge Ek, for k = 0..burst_len.
- busy is high from after E0 through after E(burst_len-1). It is low after E(burst_len), so the next request can be accepted at E(burst_len+1).
- Single reads (burst_len=0) can be accepted every cycle, giving continuous ovalid.
- Read-after-write:
  - A write at E0 followed by a read of the same address at E1 returns the new data after E1.
  - No same-edge read and write is possible on a single port.
- Any cycle without a beat drives ovalid=0 and odata=0 in that cycle.
- Reset mid-burst or mid-clear aborts immediately and asynchronously:
  - outputs take their reset values;
  - a partial clear is restarted from 0 after rst_ rises;
  - a partially written array is left as is.
- The clear sequence occupies exactly DEPTH cycles after the first clk edge with rst_ high.

## Test plan

- Clear: preload word 5 = 32'hDEADBEEF (CLEAR_ON_RESET=0 build, then a CLEAR_ON_RESET=1 build with backdoor preload); pulse rst_ -> busy high for exactly 1024 cycles, then read addr 5 returns 0.
- Byte write: write 32'h11223344 to addr 3 with be=4'hF, then 32'hAABBCCDD with be=4'b0101 -> read addr 3 returns 32'h11BB33DD one cycle after the read edge with ovalid=1.
- Burst wrap: words 1022, 1023, 0, 1 hold 10, 11, 12, 13. Read addr 1022 with burst_len=3 -> ovalid for 4 consecutive cycles with data 10, 11, 12, 13; busy high for 3 cycles; next read accepted on the following edge.
- Dropped request: during a 4-beat burst, assert cs_=0 with rw_=0 to addr 7 with data 32'h5A5A5A5A -> addr 7 is unchanged afterwards and the burst data is unaffected.
- Reset mid-burst: assert rst_=0 after beat 1 of an 8-beat burst -> odata=0, ovalid=0 immediately without waiting for clk; no further beats after release.
- Back-to-back: write addr 9 = 32'h0000_0042 at E0 and read addr 9 at E1 -> odata = 32'h0000_0042 with ovalid=1 after E1.

Source files
------------

// File: rtl/sram_burst.sv
// Single-port synchronous SRAM with byte strobes, registered read data, incrementing read
// bursts and an optional post-reset clear sequencer.
module sram_burst #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned BURST_WIDTH    = 3,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    cs_,
  input  logic                    rw_,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   idata,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [BURST_WIDTH-1:0]  burst_len,
  output logic [DATA_WIDTH-1:0]   odata,
  output logic                    ovalid,
  output logic                    busy
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {StClear, StIdle, StBurst} state_e;

  localparam state_e ResetState = (CLEAR_ON_RESET != 0) ? StClear : StIdle;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0]  odata_q;
  logic                   ovalid_q;

  logic                   mem_we;
  logic [NUM_BYTES-1:0]   mem_be;
  logic [ADDR_WIDTH-1:0]  mem_waddr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic                   rd_en;
  logic [ADDR_WIDTH-1:0]  rd_addr;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_waddr = clr_cnt_q;
    mem_wdata = '0;
    rd_en     = 1'b0;
    rd_addr   = addr_q;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_be    = '1;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (&clr_cnt_q) state_d = StIdle;
      end
      StIdle: begin
        if (!cs_) begin
          if (rw_) begin
            rd_en   = 1'b1;
            rd_addr = addr;
            if (burst_len != '0) begin
              addr_d  = addr + ADDR_WIDTH'(1);
              rem_d   = burst_len;
              state_d = StBurst;
            end
          end else begin
            mem_we    = 1'b1;
            mem_be    = be;
            mem_waddr = addr;
            mem_wdata = idata;
          end
        end
      end
      StBurst: begin
        rd_en  = 1'b1;
        addr_d = addr_q + ADDR_WIDTH'(1);
        rem_d  = rem_q - BURST_WIDTH'(1);
        if (rem_q == BURST_WIDTH'(1)) state_d = StIdle;
      end
      default: state_d = ResetState;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= ResetState;
      clr_cnt_q <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      odata_q   <= '0;
      ovalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      odata_q   <= rd_en ? mem[rd_addr] : '0;
      ovalid_q  <= rd_en;
    end
  end

  // Array contents survive reset; only the clear sequencer zeroes them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (mem_be[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_sram_burst.sv
// Randomized and directed checks of sram_burst against an array-based reference model.
module tb_sram_burst;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        rst0_ = 1'b0;
  logic        cs_ = 1'b1;
  logic        rw_ = 1'b1;
  logic [9:0]  addr = '0;
  logic [31:0] idata = '0;
  logic [3:0]  be = '0;
  logic [2:0]  burst_len = '0;
  logic [31:0] odata, odata0;
  logic        ovalid, ovalid0;
  logic        busy, busy0;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [1024];

  always #5 clk = ~clk;

  sram_burst u_dut (
    .clk(clk), .rst_(rst_), .cs_(cs_), .rw_(rw_), .addr(addr), .idata(idata), .be(be),
    .burst_len(burst_len), .odata(odata), .ovalid(ovalid), .busy(busy)
  );

  sram_burst #(.CLEAR_ON_RESET(0)) u_dut0 (
    .clk(clk), .rst_(rst0_), .cs_(cs_), .rw_(rw_), .addr(addr), .idata(idata), .be(be),
    .burst_len(burst_len), .odata(odata0), .ovalid(ovalid0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model[i] = '0;
  endtask

  // Called at the negedge where rst_ has just been released.
  task automatic wait_clear(input string tag);
    int  n = 0;
    bit  ov = 1'b0;
    while (busy && n < 3000) begin
      if (ovalid) ov = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd1024);
    chk({tag, "_no_beats"}, 64'(ov), 64'd0);
    model_clear();
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
    cs_ = 1'b0; rw_ = 1'b0; addr = a; idata = d; be = b;
    @(negedge clk);
    cs_ = 1'b1;
    chk("write_ovalid", 64'(ovalid), 64'd0);
    chk("write_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
  endtask

  // drop: issue a write to addr 7 while the burst keeps the block busy.
  task automatic do_read(input logic [9:0] a, input int len, input bit drop);
    logic [31:0] exp;
    cs_ = 1'b0; rw_ = 1'b1; addr = a; burst_len = 3'(len);
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (drop) begin
          cs_ = 1'b0; rw_ = 1'b0; addr = 10'd7; idata = 32'h5A5A5A5A; be = 4'hF;
        end else begin
          cs_ = 1'b1;
        end
      end
      if (drop && k == len - 1) cs_ = 1'b1;
      exp = model[(int'(a) + k) % 1024];
      chk("read_ovalid", 64'(ovalid), 64'd1);
      chk("read_odata", 64'(odata), 64'(exp));
      chk("read_busy", 64'(busy), 64'(k < len));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_odata", 64'(odata), 64'd0);
    chk("rst_busy_noclear", 64'(busy0), 64'd0);

    // Build without clear: usable immediately while the main instance stays in reset.
    rst0_ = 1'b1;
    cs_ = 1'b0; rw_ = 1'b0; addr = 10'd3; idata = 32'hCAFEF00D; be = 4'hF;
    @(negedge clk);
    chk("noclear_busy", 64'(busy0), 64'd0);
    rw_ = 1'b1; burst_len = '0;
    @(negedge clk);
    cs_ = 1'b1;
    chk("noclear_ovalid", 64'(ovalid0), 64'd1);
    chk("noclear_odata", 64'(odata0), 64'hCAFEF00D);
    chk("main_held_in_reset", 64'(ovalid), 64'd0);

    rst_ = 1'b1;
    wait_clear("clear1");

    // Byte strobes merge into the existing word.
    do_write(10'd3, 32'h11223344, 4'hF);
    do_write(10'd3, 32'hAABBCCDD, 4'b0101);
    do_read(10'd3, 0, 1'b0);
    chk("byte_merge_model", 64'(model[3]), 64'h11BB33DD);

    // Burst wrap across the top of the array, then an immediate follow-up read.
    do_write(10'd1022, 32'd10, 4'hF);
    do_write(10'd1023, 32'd11, 4'hF);
    do_write(10'd0, 32'd12, 4'hF);
    do_write(10'd1, 32'd13, 4'hF);
    do_read(10'd1022, 3, 1'b0);
    do_read(10'd0, 0, 1'b0);
    @(negedge clk);
    chk("idle_ovalid", 64'(ovalid), 64'd0);
    chk("idle_odata", 64'(odata), 64'd0);

    // A write presented during a burst must be dropped.
    do_write(10'd7, 32'h01020304, 4'hF);
    do_write(10'd20, 32'h77, 4'hF);
    do_read(10'd20, 3, 1'b1);
    do_read(10'd7, 0, 1'b0);

    // Read-after-write on consecutive edges.
    do_write(10'd9, 32'h0000_0042, 4'hF);
    do_read(10'd9, 0, 1'b0);

    // Back-to-back single reads give continuous ovalid.
    for (int i = 0; i < 4; i++) do_read(10'(1020 + i), 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(1, 0) == 1)
        do_write(10'($urandom), $urandom, 4'($urandom));
      else
        do_read(10'($urandom), int'($urandom_range(7, 0)), 1'b0);
    end

    // Reset re-runs the clear and zeroes previously written data.
    do_write(10'd5, 32'hDEADBEEF, 4'hF);
    do_read(10'd5, 0, 1'b0);
    rst_ = 1'b0;
    #1;
    chk("rst2_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst_ = 1'b1;
    wait_clear("clear2");
    do_read(10'd5, 0, 1'b0);

    // Asynchronous reset in the middle of an 8-beat burst.
    do_write(10'd100, 32'h12345678, 4'hF);
    do_write(10'd101, 32'h9ABCDEF0, 4'hF);
    cs_ = 1'b0; rw_ = 1'b1; addr = 10'd100; burst_len = 3'd7;
    @(negedge clk);
    cs_ = 1'b1;
    chk("mid_beat0", 64'(odata), 64'h12345678);
    @(negedge clk);
    chk("mid_beat1", 64'(odata), 64'h9ABCDEF0);
    chk("mid_beat1_valid", 64'(ovalid), 64'd1);
    #2 rst_ = 1'b0;
    #1;
    chk("async_rst_ovalid", 64'(ovalid), 64'd0);
    chk("async_rst_odata", 64'(odata), 64'd0);
    @(negedge clk);
    rst_ = 1'b1;
    wait_clear("clear3");
    do_read(10'd100, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
